// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic-computing (DSC) blocks.
package dsc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dsc_state_t;

  // Cycle counter must hold 2^(2*width), one more than the product range.
  function automatic int dsc_cyc_w(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/dsc_mul_es_param_if.sv
// Start/done handshake and operand/result bus of the DSC multiplier.
interface dsc_mul_es_param_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   z;
  logic [2*WIDTH:0]     cycles;

  modport master (output start, a, b, input busy, done, z, cycles);
  modport slave  (input start, a, b, output busy, done, z, cycles);
endinterface

// File: rtl/dsc_unary_sng.sv
// Unary stream generator: free counter compared against a value; the stream
// bit is high for the first 'value' counts of every 2^WIDTH period.
module dsc_unary_sng #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             bit_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise advance (mod 2^WIDTH) when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + WIDTH'(1);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_o  = (cnt_q < value_i);
  // Wrap flags the increment that rolls the counter back to zero.
  assign wrap_o = en_i & (cnt_q == '1);

endmodule

// File: rtl/dsc_mul_es_param.sv
// DSC multiplier: A stream cycles every clock, B stream advances once per
// A period; ANDed ones are counted into an exact 2*WIDTH-bit product.
// ES_EN stops the run as soon as the B stream is permanently zero.
module dsc_mul_es_param
  import dsc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit ES_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  dsc_mul_es_param_if.slave   bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = dsc_cyc_w(WIDTH);

  dsc_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d, z_q;
  logic [CW-1:0]    cyc_q, cyc_d, cycles_q;
  logic             busy_q, done_q;
  logic             clr, adv, sa, sb, wrap_a, wrap_b, en_b, finish;

  assign en_b = adv & wrap_a;

  dsc_unary_sng #(.WIDTH(WIDTH)) u_sng_a (
    .clk    (clk),
    .rst    (rst),
    .en_i   (adv),
    .clr_i  (clr),
    .value_i(a_q),
    .bit_o  (sa),
    .wrap_o (wrap_a)
  );

  dsc_unary_sng #(.WIDTH(WIDTH)) u_sng_b (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_b),
    .clr_i  (clr),
    .value_i(b_q),
    .bit_o  (sb),
    .wrap_o (wrap_b)
  );

  // FSM next state, operand latch, accumulate and cycle count.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cyc_d   = cyc_q;
    clr     = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          cyc_d   = '0;
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        cyc_d = cyc_q + CW'(1);
        if (ES_EN && !sb) begin
          // B stream exhausted: every further product bit would be zero.
          state_d = DONE;
        end else begin
          adv   = 1'b1;
          acc_d = acc_q + PW'(sa & sb);
          if (!ES_EN && wrap_a && wrap_b) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign finish = (state_q == RUN) && (state_d == DONE);

  // State, datapath and output registers; outputs load on entry to DONE so
  // z/cycles are already valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cyc_q    <= '0;
      z_q      <= '0;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cyc_q   <= cyc_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (finish) begin
        z_q      <= acc_d;
        cycles_q <= cyc_d;
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.z      = z_q;
  assign bus.cycles = cycles_q;

endmodule
